// File: rtl/p2s_4bit.sv
// p2s_4bit: parallel-to-serial transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake into a holding register,
// moves it into a shift register and sends one bit per clock on dout_o, with
// sync_o marking the first bit of each word. Words queued in time stream with
// no idle gap; a word ending with nothing queued raises a one-cycle underrun.
//
// Ports:
//   clk_i       clock, rising edge
//   clr_n_i     asynchronous active-low reset
//   p_i         parallel word, sampled when load_i & ready_o
//   load_i      word-valid request
//   ready_o     holding register empty (registered)
//   dout_o      serial data (registered)
//   sync_o      high during the first bit of each word (registered)
//   busy_o      high while a word is on dout_o (registered)
//   underrun_o  one-cycle pulse: word finished with nothing queued (registered)
module p2s_4bit #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             load_i,
  output logic             ready_o,
  output logic             dout_o,
  output logic             sync_o,
  output logic             busy_o,
  output logic             underrun_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               ready_q, ready_d;
  logic               dout_q, dout_d;
  logic               sync_q, sync_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;

  logic               accept_c;

  // ready_q mirrors !hold_full_q, so an accept can never coincide with a transfer
  assign accept_c = load_i & ready_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          sr_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (hold_full_q) begin
            // Back-to-back: next word starts on the very next cycle
            sr_d        = hold_q;
            hold_full_d = 1'b0;
          end else begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (MSB_FIRST != 0) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
          end else begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      hold_d      = p_i;
      hold_full_d = 1'b1;
    end

    // Outputs derived from next state so they are valid right after the edge
    busy_d  = (state_d == SHIFT);
    sync_d  = (state_d == SHIFT) && (cnt_d == '0);
    ready_d = !hold_full_d;
    if (state_d == SHIFT) begin
      dout_d = (MSB_FIRST != 0) ? sr_d[WIDTH-1] : sr_d[0];
    end else begin
      dout_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      dout_q      <= 1'b0;
      sync_q      <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      dout_q      <= dout_d;
      sync_q      <= sync_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ready_o    = ready_q;
  assign dout_o     = dout_q;
  assign sync_o     = sync_q;
  assign busy_o     = busy_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_p2s_4bit.sv
// Directed bench for p2s_4bit: a 4-bit LSB-first instance and an 8-bit
// MSB-first instance share clock and reset. Outputs are sampled on the
// falling edge into per-cycle traces; trace index 0 is the cycle after the
// accept edge of the first word of each step.
module tb_p2s_4bit;

  logic       clk;
  logic       clr_n;
  logic [3:0] p_a;
  logic       load_a;
  logic       ready_a, dout_a, sync_a, busy_a, ur_a;
  logic [7:0] p_b;
  logic       load_b;
  logic       ready_b, dout_b, sync_b, busy_b, ur_b;

  int n_err;
  int n_checks;

  logic tr_dout_a[$];
  logic tr_sync_a[$];
  logic tr_busy_a[$];
  logic tr_ur_a[$];
  logic tr_rdy_a[$];
  logic tr_dout_b[$];
  logic tr_sync_b[$];
  logic tr_busy_b[$];
  logic tr_ur_b[$];

  p2s_4bit #(.WIDTH(4), .MSB_FIRST(0)) dut_a (
    .clk_i      (clk),
    .clr_n_i    (clr_n),
    .p_i        (p_a),
    .load_i     (load_a),
    .ready_o    (ready_a),
    .dout_o     (dout_a),
    .sync_o     (sync_a),
    .busy_o     (busy_a),
    .underrun_o (ur_a)
  );

  p2s_4bit #(.WIDTH(8), .MSB_FIRST(1)) dut_b (
    .clk_i      (clk),
    .clr_n_i    (clr_n),
    .p_i        (p_b),
    .load_i     (load_b),
    .ready_o    (ready_b),
    .dout_o     (dout_b),
    .sync_o     (sync_b),
    .busy_o     (busy_b),
    .underrun_o (ur_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_traces();
    tr_dout_a.delete(); tr_sync_a.delete(); tr_busy_a.delete();
    tr_ur_a.delete();   tr_rdy_a.delete();
    tr_dout_b.delete(); tr_sync_b.delete(); tr_busy_b.delete();
    tr_ur_b.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    tr_dout_a.push_back(dout_a);
    tr_sync_a.push_back(sync_a);
    tr_busy_a.push_back(busy_a);
    tr_ur_a.push_back(ur_a);
    tr_rdy_a.push_back(ready_a);
    tr_dout_b.push_back(dout_b);
    tr_sync_b.push_back(sync_b);
    tr_busy_b.push_back(busy_b);
    tr_ur_b.push_back(ur_b);
  endtask

  function automatic logic bitchar(input string s, input int i);
    return (s[i] == "1");
  endfunction

  initial begin
    string bb_str;
    string bp_str;
    string rs_str;
    string mb_str;
    logic [3:0] q_rx;
    int ur_cnt;

    n_err    = 0;
    n_checks = 0;
    clr_n    = 1'b1;
    p_a      = '0;
    load_a   = 1'b0;
    p_b      = '0;
    load_b   = 1'b0;

    // ---- Reset held across edges, then released
    #1 clr_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_dout_a",  32'(dout_a),  32'd0);
    chk("rst_sync_a",  32'(sync_a),  32'd0);
    chk("rst_busy_a",  32'(busy_a),  32'd0);
    chk("rst_ur_a",    32'(ur_a),    32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd1);
    chk("rst_busy_b",  32'(busy_b),  32'd0);
    clr_n = 1'b1;
    clear_traces();
    repeat (3) tick();
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("idle_busy_a[%0d]", t),  32'(tr_busy_a[t]), 32'd0);
      chk($sformatf("idle_dout_a[%0d]", t),  32'(tr_dout_a[t]), 32'd0);
      chk($sformatf("idle_ready_a[%0d]", t), 32'(tr_rdy_a[t]),  32'd1);
    end

    // ---- Single word 4'b1011, LSB first
    clear_traces();
    p_a = 4'b1011; load_a = 1'b1;
    tick();                       // t0: accepted
    load_a = 1'b0;
    repeat (6) tick();            // t1..t6
    chk("sw_ready_t0", 32'(tr_rdy_a[0]),  32'd0);
    chk("sw_busy_t0",  32'(tr_busy_a[0]), 32'd0);
    chk("sw_ready_t1", 32'(tr_rdy_a[1]),  32'd1);
    chk("sw_dout_t1",  32'(tr_dout_a[1]), 32'd1);
    chk("sw_dout_t2",  32'(tr_dout_a[2]), 32'd1);
    chk("sw_dout_t3",  32'(tr_dout_a[3]), 32'd0);
    chk("sw_dout_t4",  32'(tr_dout_a[4]), 32'd1);
    chk("sw_sync_t1",  32'(tr_sync_a[1]), 32'd1);
    chk("sw_sync_t2",  32'(tr_sync_a[2]), 32'd0);
    chk("sw_sync_t4",  32'(tr_sync_a[4]), 32'd0);
    chk("sw_busy_t4",  32'(tr_busy_a[4]), 32'd1);
    chk("sw_ur_t4",    32'(tr_ur_a[4]),   32'd0);
    chk("sw_ur_t5",    32'(tr_ur_a[5]),   32'd1);
    chk("sw_busy_t5",  32'(tr_busy_a[5]), 32'd0);
    chk("sw_dout_t5",  32'(tr_dout_a[5]), 32'd0);
    chk("sw_ur_t6",    32'(tr_ur_a[6]),   32'd0);
    // Looped-back receiver: first captured bit lands in q[0]
    for (int k = 0; k < 4; k++) q_rx[k] = tr_dout_a[1 + k];
    chk("sw_rx_q", 32'(q_rx), 32'hB);

    // ---- Back-to-back 4'hA, 4'h5, 4'hF (accepted at t-edges 0, 2, 6)
    clear_traces();
    p_a = 4'hA; load_a = 1'b1;
    tick();                       // t0: A accepted
    p_a = 4'h5;
    tick();                       // t1: A moved to shifter
    tick();                       // t2: 5 accepted
    p_a = 4'hF;
    repeat (4) tick();            // t3..t6: F accepted at edge before t6
    load_a = 1'b0;
    repeat (9) tick();            // t7..t15
    bb_str = "010110101111";
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("bb_dout[%0d]", i), 32'(tr_dout_a[1 + i]), 32'(bitchar(bb_str, i)));
      chk($sformatf("bb_busy[%0d]", i), 32'(tr_busy_a[1 + i]), 32'd1);
      chk($sformatf("bb_sync[%0d]", i), 32'(tr_sync_a[1 + i]), 32'((i % 4) == 0));
    end
    chk("bb_ur_t13",   32'(tr_ur_a[13]),   32'd1);
    chk("bb_busy_t13", 32'(tr_busy_a[13]), 32'd0);
    ur_cnt = 0;
    foreach (tr_ur_a[t]) ur_cnt += int'(tr_ur_a[t]);
    chk("bb_ur_count", 32'(ur_cnt), 32'd1);

    // ---- Backpressure: 4'h9 sending, 4'hC queued, 4'h3 offered while full
    clear_traces();
    p_a = 4'h9; load_a = 1'b1;
    tick();                       // t0: 9 accepted
    load_a = 1'b0;
    tick();                       // t1
    p_a = 4'hC; load_a = 1'b1;
    tick();                       // t2: C accepted
    chk("bp_ready_full", 32'(ready_a), 32'd0);
    p_a = 4'h3; load_a = 1'b1;
    tick();                       // t3: ignored
    load_a = 1'b0;
    repeat (9) tick();            // t4..t12
    bp_str = "10010011";
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_dout[%0d]", i), 32'(tr_dout_a[1 + i]), 32'(bitchar(bp_str, i)));
    end
    chk("bp_ready_t3", 32'(tr_rdy_a[3]),  32'd0);
    chk("bp_ready_t4", 32'(tr_rdy_a[4]),  32'd0);
    chk("bp_ready_t5", 32'(tr_rdy_a[5]),  32'd1);
    chk("bp_sync_t5",  32'(tr_sync_a[5]), 32'd1);
    chk("bp_ur_t9",    32'(tr_ur_a[9]),   32'd1);
    for (int t = 9; t < 13; t++) begin
      chk($sformatf("bp_busy_t%0d", t), 32'(tr_busy_a[t]), 32'd0);
    end
    ur_cnt = 0;
    foreach (tr_ur_a[t]) ur_cnt += int'(tr_ur_a[t]);
    chk("bp_ur_count", 32'(ur_cnt), 32'd1);

    // ---- Reset mid-word while 4'hC is on the line
    clear_traces();
    p_a = 4'hC; load_a = 1'b1;
    tick();                       // t0
    load_a = 1'b0;
    repeat (3) tick();            // t1..t3, bit 2 (=1) on the line at t3
    chk("mr_pre_dout", 32'(tr_dout_a[3]), 32'd1);
    chk("mr_pre_busy", 32'(tr_busy_a[3]), 32'd1);
    #2 clr_n = 1'b0;
    #1;
    chk("mr_dout",  32'(dout_a),  32'd0);
    chk("mr_busy",  32'(busy_a),  32'd0);
    chk("mr_sync",  32'(sync_a),  32'd0);
    chk("mr_ready", 32'(ready_a), 32'd1);
    @(negedge clk);
    clr_n = 1'b1;
    clear_traces();
    p_a = 4'h6; load_a = 1'b1;
    tick();                       // t0: accepted on first edge after release
    load_a = 1'b0;
    repeat (6) tick();
    chk("mr_ready_t0", 32'(tr_rdy_a[0]), 32'd0);
    rs_str = "0110";
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mr_dout[%0d]", i), 32'(tr_dout_a[1 + i]), 32'(bitchar(rs_str, i)));
      chk($sformatf("mr_sync[%0d]", i), 32'(tr_sync_a[1 + i]), 32'(i == 0));
    end
    chk("mr_ur_t5", 32'(tr_ur_a[5]), 32'd1);

    // ---- 8-bit MSB-first: 8'h81 then 8'h02 back-to-back
    clear_traces();
    p_b = 8'h81; load_b = 1'b1;
    tick();                       // t0: 81 accepted
    p_b = 8'h02;
    tick();                       // t1
    tick();                       // t2: 02 accepted
    load_b = 1'b0;
    repeat (18) tick();           // t3..t20
    mb_str = "1000000100000010";
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("mb_dout[%0d]", i), 32'(tr_dout_b[1 + i]), 32'(bitchar(mb_str, i)));
      chk($sformatf("mb_sync[%0d]", i), 32'(tr_sync_b[1 + i]), 32'((i % 8) == 0));
      chk($sformatf("mb_busy[%0d]", i), 32'(tr_busy_b[1 + i]), 32'd1);
    end
    chk("mb_ur_t16",   32'(tr_ur_b[16]),   32'd0);
    chk("mb_ur_t17",   32'(tr_ur_b[17]),   32'd1);
    chk("mb_busy_t17", 32'(tr_busy_b[17]), 32'd0);
    chk("mb_dout_t17", 32'(tr_dout_b[17]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/p2s_4bit.md
# p2s_4bit

Parallel-to-serial transmitter: accepts a WIDTH-bit word through a valid/ready handshake, double-buffers it and shifts it out one bit per clock on DOUT, with a SYNC strobe marking the first bit of every word. It is the transmit end of the 4-bit serial link whose receiver reassembles words from the same one-bit-per-clock stream. Default bit order is LSB first, so the receiver's first-captured bit lands in Q[0]. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 4: word width in bits; legal range ≥ 2.
- MSB_FIRST, 0: 0 = transmit P[0] first; 1 = transmit P[WIDTH-1] first.
- CLK  input  1  clock; all state changes on rising edge.
- CLR_N  input  1  asynchronous, active-low reset.
- P  input  WIDTH  parallel word to send; sampled when LOAD & READY.
- LOAD  input  1  word-valid request.
- READY  output  1  holding register empty; word accepted on an edge where LOAD & READY.
- DOUT  output  1  serial data, registered.
- SYNC  output  1  registered; high during the first bit of each word.
- BUSY  output  1  registered; high while a word is on DOUT.
- UNDERRUN  output  1  one-cycle registered pulse; a word finished with nothing queued.

## Operation
- Storage: holding register HOLD plus full flag; shift register SR; bit counter CNT of width $clog2(WIDTH), counting 0..WIDTH-1.
- READY = !HOLD_full, registered.
- Accept: on an edge with LOAD & READY, HOLD <= P and HOLD_full <= 1. LOAD while READY=0 is ignored; P is not sampled.
- FSM states:
  - IDLE: DOUT=0, SYNC=0, BUSY=0. On an edge with HOLD_full=1: SR <= HOLD, HOLD_full <= 0, CNT <= 0, go to SHIFT.
  - SHIFT: output the current bit; CNT increments each edge.
- Last bit (CNT == WIDTH-1):
  - If HOLD_full: reload SR from HOLD, CNT <= 0, stay in SHIFT (back-to-back).
  - Otherwise: go to IDLE and pulse UNDERRUN for one cycle.
- Bit order:
  - MSB_FIRST=0: DOUT = SR[0]; shift right.
  - MSB_FIRST=1: DOUT = SR[WIDTH-1]; shift left.
- SYNC = 1 exactly when CNT == 0 in SHIFT. BUSY = (state == SHIFT).
- Simultaneous accept and transfer cannot occur: READY=0 whenever HOLD is full. An accept on the same edge HOLD empties is impossible, because READY rises only on the edge after the transfer.
- Reset (CLR_N=0, any time, including mid-word):
  - State IDLE, CNT=0, SR=0, HOLD=0, HOLD_full=0.
  - Outputs: DOUT=0, SYNC=0, BUSY=0, UNDERRUN=0, READY=1.
  - A partial word is discarded. Outputs change asynchronously on CLR_N falling.
  - The first accept is possible on the first rising edge with CLR_N=1.

## Timing
- Accept at edge e0; READY=0 after e0.
- Edge e0+1 (idle start): SR loaded; SYNC=1, BUSY=1, DOUT = first bit; READY=1 again.
- Bit k is valid on DOUT in the cycle after edge e0+1+k, for k = 0..WIDTH-1.
- Latency from accept edge to first bit on DOUT: 1 cycle.
- Sustained throughput: 1 word per WIDTH cycles.
  - HOLD frees at the start of each word, leaving WIDTH-1 cycles in which to supply the next word.
  - A word accepted at any edge up to and including the last-bit edge follows with no gap, and SYNC is high again on the next cycle.
- Underrun: after the last bit's cycle, DOUT=0, BUSY=0, and UNDERRUN=1 for that single cycle.
- A word accepted later restarts with the 1-cycle idle-start latency.

## Test plan
- Reset: hold CLR_N=0 across edges, then release. Required: READY=1, DOUT=SYNC=BUSY=UNDERRUN=0; no activity until LOAD.
- Single word, WIDTH=4, MSB_FIRST=0: P=4'b1011 with LOAD for one edge. Required: DOUT = 1,1,0,1 on 4 consecutive cycles starting 1 cycle after accept; SYNC only on the first; UNDERRUN pulse after the 4th; a looped-back receiver shows Q=4'b1011.
- Back-to-back: hold LOAD=1 with 4'hA, 4'h5, 4'hF. Required: 12 contiguous bits 0,1,0,1,1,0,1,0,1,1,1,1; SYNC every 4th cycle; BUSY continuously high; UNDERRUN only after the last word.
- Backpressure: pulse LOAD with 4'h3 while HOLD is full. Required: READY=0 and the word is ignored; the sent stream contains no 4'h3.
- Reset mid-word: assert CLR_N=0 after 2 bits of 4'hC. Required: DOUT, BUSY and SYNC go to 0 immediately; the next accepted 4'h6 transmits cleanly as 0,1,1,0.
- MSB_FIRST=1, WIDTH=8: send 8'h81 followed by 8'h02. Required: 1,0,0,0,0,0,0,1 then 0,0,0,0,0,0,1,0; SYNC on bits 0 and 8.
